// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the EX-stage multiply/divide unit:
// op encodings, FSM states and the default datapath width.
package mips_pkg;

   localparam int unsigned MULDIV_DATA_W = 32;

   typedef enum logic [2:0] {
      MD_NOP   = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_NOP7  = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the final product/quotient/remainder sign correction.
module muldiv_signfix #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] val_i,
   input  logic              neg_i,
   output logic [DATA_W-1:0] res_o
);

   always_comb begin
      res_o = neg_i ? (~val_i + 1'b1) : val_i;
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path (divide stays iterative).
module ex_muldiv_unit
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = MULDIV_DATA_W,
   parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              dz_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   muldiv_op_e          op;
   muldiv_state_e       state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   opnd;      // multiplicand or divisor magnitude
   logic [2*DATA_W-1:0] acc;       // {partial product | remainder, multiplier | quotient}
   logic [DATA_W-1:0]   raw_dvd;
   logic                is_div;
   logic                res_neg;
   logic                rem_neg;
   logic                div_zero;

   logic                op_signed;
   logic [DATA_W-1:0]   rs_abs;
   logic [DATA_W-1:0]   rt_abs;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic [2*DATA_W-1:0] fix_src;
   logic [2*DATA_W-1:0] fix_res;
   logic [DATA_W-1:0]   rem_res;

   assign op        = muldiv_op_e'(op_i);
   assign op_signed = (op == MD_MULT) || (op == MD_DIV);

   muldiv_signfix #(.DATA_W(DATA_W)) u_abs_rs (
      .val_i (rs_data_i),
      .neg_i (op_signed & rs_data_i[DATA_W-1]),
      .res_o (rs_abs)
   );

   muldiv_signfix #(.DATA_W(DATA_W)) u_abs_rt (
      .val_i (rt_data_i),
      .neg_i (op_signed & rt_data_i[DATA_W-1]),
      .res_o (rt_abs)
   );

   // Negating the full 2W value also negates its low half, so one
   // instance serves both the product and the quotient.
   muldiv_signfix #(.DATA_W(2*DATA_W)) u_fix_res (
      .val_i (fix_src),
      .neg_i (res_neg),
      .res_o (fix_res)
   );

   muldiv_signfix #(.DATA_W(DATA_W)) u_fix_rem (
      .val_i (acc[2*DATA_W-1:DATA_W]),
      .neg_i (rem_neg),
      .res_o (rem_res)
   );

   always_comb begin
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opnd};
`ifdef MULDIV_FAST_MUL_EN
      fix_src   = is_div ? acc
                         : ({{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]});
`else
      fix_src   = acc;
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         opnd     <= '0;
         acc      <= '0;
         raw_dvd  <= '0;
         is_div   <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         dz_o     <= 1'b0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else begin
         done_o <= 1'b0;
         dz_o   <= 1'b0;
         case (state)
            MD_IDLE: begin
               if (start_i && !flush_i) begin
                  case (op)
                     MD_MTHI: hi_o <= rs_data_i;
                     MD_MTLO: lo_o <= rs_data_i;
                     MD_MULT, MD_MULTU: begin
                        opnd     <= rs_abs;
                        acc      <= {{DATA_W{1'b0}}, rt_abs};
                        is_div   <= 1'b0;
                        res_neg  <= op_signed & (rs_data_i[DATA_W-1] ^ rt_data_i[DATA_W-1]);
                        rem_neg  <= 1'b0;
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        busy_o   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state    <= MD_FIX;
`else
                        state    <= MD_RUN;
`endif
                     end
                     MD_DIV, MD_DIVU: begin
                        opnd     <= rt_abs;
                        acc      <= {{DATA_W{1'b0}}, rs_abs};
                        raw_dvd  <= rs_data_i;
                        is_div   <= 1'b1;
                        res_neg  <= op_signed & (rs_data_i[DATA_W-1] ^ rt_data_i[DATA_W-1]);
                        rem_neg  <= op_signed & rs_data_i[DATA_W-1];
                        div_zero <= (rt_data_i == '0);
                        cnt      <= '0;
                        busy_o   <= 1'b1;
                        state    <= MD_RUN;
                     end
                     default: ;
                  endcase
               end
            end
            MD_RUN: begin
               if (flush_i) begin
                  busy_o <= 1'b0;
                  state  <= MD_IDLE;
               end else begin
                  if (is_div) begin
                     // Restoring step: keep the trial difference only if it did not borrow.
                     if (!div_diff[DATA_W])
                        acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                     else
                        acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
                  end else begin
                     acc <= {mul_sum, acc[DATA_W-1:1]};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST)
                     state <= MD_FIX;
               end
            end
            MD_FIX: begin
               busy_o <= 1'b0;
               state  <= MD_IDLE;
               if (!flush_i) begin
                  done_o <= 1'b1;
                  if (is_div) begin
                     if (div_zero) begin
                        hi_o <= raw_dvd;
                        lo_o <= '1;
                        dz_o <= 1'b1;
                     end else begin
                        hi_o <= rem_res;
                        lo_o <= fix_res[DATA_W-1:0];
                     end
                  end else begin
                     hi_o <= fix_res[2*DATA_W-1:DATA_W];
                     lo_o <= fix_res[DATA_W-1:0];
                  end
               end
            end
            default: begin
               busy_o <= 1'b0;
               state  <= MD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// ops against an arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        flush;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   ex_muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .op_i      (op),
      .rs_data_i (rs),
      .rt_data_i (rt),
      .flush_i   (flush),
      .busy_o    (busy),
      .done_o    (done),
      .dz_o      (dz),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference semantics of each op on the architectural HI/LO pair.
   function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output bit z);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      z  = 1'b0;
      case (o)
         3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
         3'd3, 3'd4: begin
            if (b == 32'd0) begin
               z = 1'b1; h = a; l = '1;
            end else if (o == 3'd3) begin
               p = 64'(sa / sb); l = p[31:0];
               p = 64'(sa % sb); h = p[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
         3'd5: h = a;
         3'd6: l = a;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      logic [31:0] eh;
      logic [31:0] el;
      bit          edz;
      int          nb;
      int          nd;
      int          exp_busy;
      bit          md;
      eh = m_hi;
      el = m_lo;
      ref_op(o, a, b, eh, el, edz);
      md = (o >= 3'd1) && (o <= 3'd4);
      exp_busy = (FAST && (o == 3'd1 || o == 3'd2)) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; op = o; rs = a; rt = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      if (md) begin
         nb = 0;
         nd = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inject && i == 5) begin
               start = 1'b1; op = 3'd3; rs = 32'hFFFF_FFCE; rt = 32'd3;
            end
            if (inject && i == 6) begin
               start = 1'b0; op = 3'd0;
            end
            if (done) nd++;
            if (!busy) break;
            nb++;
         end
         check("busy_cycles", 64'(nb), 64'(exp_busy));
         check("done_pulses", 64'(nd), 64'd1);
         check("dz", 64'(dz), 64'(edz));
      end else begin
         @(negedge clk);
         check("busy_idle", 64'(busy), 64'd0);
         check("done_idle", 64'(done), 64'd0);
      end
      check("hi", 64'(hi), 64'(eh));
      check("lo", 64'(lo), 64'(el));
      if (md) begin
         @(negedge clk);
         check("done_single", 64'(done), 64'd0);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic expect_quiet(input string tag);
      int nd;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      check(tag, 64'(nd), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(m_hi));
      check({tag, "_lo"}, 64'(lo), 64'(m_lo));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; op = 3'd0; rs = '0; rt = '0; flush = 1'b0;
      #2;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(dz), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(3'd1, 32'hFFFF_FFFF, 32'd5, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd4, 32'd100, 32'd0, 1'b0);
      run_op(3'd3, 32'hFFFF_FF9C, 32'd0, 1'b0);
      run_op(3'd1, 32'd3, 32'd4, 1'b0);

      // Flush mid-RUN leaves HI/LO untouched.
      run_op(3'd5, 32'h1234, 32'd0, 1'b0);
      run_op(3'd6, 32'h5678, 32'd0, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 3'd4; rs = 32'd100; rt = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      expect_quiet("flush_quiet");

      // Reset mid-RUN clears everything.
      @(negedge clk);
      start = 1'b1; op = 3'd4; rs = 32'd100; rt = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_done", 64'(done), 64'd0);
      check("rstmid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      expect_quiet("rstmid_quiet");

      // A start while busy must not disturb the running divide.
      run_op(3'd3, 32'd100, 32'd7, 1'b1);

      // Start together with flush in IDLE is dropped, MTHI included.
      @(negedge clk);
      start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4; flush = 1'b1;
      @(posedge clk);
      #1;
      op = 3'd5; rs = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0; flush = 1'b0;
      expect_quiet("start_flush");

      for (int k = 0; k < 40; k++)
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
